mux_4_1_8_bit: RTL and testbench

Registered 4-to-1 multiplexer for 8-bit codes with an active-high enable. Selects one of four input codes by a 2-bit select, gates it with the enable, and presents it on a registered output with a matching valid flag. Used as a datapath steering element between combinational code generators and downstream registered logic in the combinational-circuits datapath.

---
 rtl/mux_4_1_8_bit_if.sv | 35 +++
 rtl/mux_4_1_8_bit.sv | 54 +++++
 tb/tb_mux_4_1_8_bit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mux_4_1_8_bit_if.sv
// Bus bundle for the registered 4-to-1 code multiplexer.
// The o_parity signal exists only when MUX_4_1_8_BIT_PARITY_EN is defined.
interface mux_4_1_8_bit_if #(
  parameter int WIDTH = 8
);
  logic             i_en;
  logic [WIDTH-1:0] i_code_0;
  logic [WIDTH-1:0] i_code_1;
  logic [WIDTH-1:0] i_code_2;
  logic [WIDTH-1:0] i_code_3;
  logic [1:0]       i_sel_code;
  logic [WIDTH-1:0] o_code;
  logic             o_valid;
`ifdef MUX_4_1_8_BIT_PARITY_EN
  logic             o_parity;
`endif

  // Driver side: code generators and select/enable control.
  modport master (
    output i_en, i_code_0, i_code_1, i_code_2, i_code_3, i_sel_code,
`ifdef MUX_4_1_8_BIT_PARITY_EN
    input  o_parity,
`endif
    input  o_code, o_valid
  );

  // Multiplexer side.
  modport slave (
    input  i_en, i_code_0, i_code_1, i_code_2, i_code_3, i_sel_code,
`ifdef MUX_4_1_8_BIT_PARITY_EN
    output o_parity,
`endif
    output o_code, o_valid
  );
endinterface

// File: rtl/mux_4_1_8_bit.sv
// Registered 4-to-1 multiplexer with enable gating and a matching valid flag.
// Optional even-parity output enabled by defining MUX_4_1_8_BIT_PARITY_EN.
module mux_4_1_8_bit #(
  parameter int WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mux_4_1_8_bit_if.slave        bus
);

  logic [WIDTH-1:0] next_code;
  logic [WIDTH-1:0] code_q;
  logic             valid_q;

  // NOTE: next_code is defaulted before the case so no path leaves it unassigned, avoiding a latch.
  always_comb begin
    next_code = '0;
    if (bus.i_en) begin
      unique case (bus.i_sel_code)
        2'b00: next_code = bus.i_code_0;
        2'b01: next_code = bus.i_code_1;
        2'b10: next_code = bus.i_code_2;
        2'b11: next_code = bus.i_code_3;
      endcase
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      code_q  <= next_code;
      valid_q <= bus.i_en;
    end
  end

  assign bus.o_code  = code_q;
  assign bus.o_valid = valid_q;

`ifdef MUX_4_1_8_BIT_PARITY_EN
  logic parity_q;

  // Parity is taken from the pre-register value so it lines up with o_code.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) parity_q <= 1'b0;
    else       parity_q <= ^next_code;
  end

  assign bus.o_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_4_1_8_bit.sv
// Self-checking bench for mux_4_1_8_bit: vector table, corner sequences and
// randomized traffic against a behavioural model.
module tb_mux_4_1_8_bit;
  localparam int WIDTH = 8;

  typedef struct {
    logic       en;
    logic [1:0] sel;
    logic [7:0] exp_code;
    logic       exp_valid;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mux_4_1_8_bit_if #(.WIDTH(WIDTH)) bus ();

  mux_4_1_8_bit #(.WIDTH(WIDTH)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_codes(input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3);
    bus.i_code_0 = c0;
    bus.i_code_1 = c1;
    bus.i_code_2 = c2;
    bus.i_code_3 = c3;
  endtask

  // Drive inputs, let one rising edge capture them, then settle past the edge.
  task automatic step(input logic en, input logic [1:0] sel);
    bus.i_en       = en;
    bus.i_sel_code = sel;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_outputs(input string name, input logic [7:0] exp_code, input logic exp_valid);
    check({name, ".code"}, 32'(bus.o_code), 32'(exp_code));
    check({name, ".valid"}, 32'(bus.o_valid), 32'(exp_valid));
`ifdef MUX_4_1_8_BIT_PARITY_EN
    check({name, ".parity"}, 32'(bus.o_parity), 32'($countones(exp_code) % 2));
`endif
  endtask

  initial begin
    vec_t       vecs[$];
    logic [7:0] model_codes[4];
    logic [7:0] exp_q;

    // Reset applied with an active selection: outputs must be zero before any edge.
    set_codes(8'h80, 8'h40, 8'hC0, 8'h20);
    bus.i_en       = 1'b1;
    bus.i_sel_code = 2'b10;
    #2;
    check_outputs("reset_immediate", 8'h00, 1'b0);
    @(posedge i_clk); @(posedge i_clk); #1;
    check_outputs("reset_held", 8'h00, 1'b0);
    i_rst = 1'b0;

    // Select sweep, enable low/high, and the {en,sel} counter sweep.
    vecs.push_back('{1'b1, 2'd0, 8'h80, 1'b1});
    vecs.push_back('{1'b1, 2'd1, 8'h40, 1'b1});
    vecs.push_back('{1'b1, 2'd2, 8'hC0, 1'b1});
    vecs.push_back('{1'b1, 2'd3, 8'h20, 1'b1});
    vecs.push_back('{1'b0, 2'd2, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 2'd3, 8'h20, 1'b1});
    for (int i = 0; i < 8; i++) begin
      logic [7:0] cnt_exp[8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h40, 8'hC0, 8'h20};
      vecs.push_back('{i[2], i[1:0], cnt_exp[i], i[2]});
    end
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].sel);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_code, vecs[i].exp_valid);
    end

`ifdef MUX_4_1_8_BIT_PARITY_EN
    step(1'b1, 2'd2);
    check("parity_c0", 32'(bus.o_parity), 32'd0);
    step(1'b1, 2'd0);
    check("parity_80", 32'(bus.o_parity), 32'd1);
    step(1'b0, 2'd0);
    check("parity_off", 32'(bus.o_parity), 32'd0);
`endif

    // Mid-stream reset pulse between edges, then resume.
    step(1'b1, 2'd2);
    check_outputs("stream_pre", 8'hC0, 1'b1);
    #2 i_rst = 1'b1;
    #1;
    check_outputs("midreset_drop", 8'h00, 1'b0);
    #2 i_rst = 1'b0;
    @(posedge i_clk); #1;
    check_outputs("midreset_resume", 8'hC0, 1'b1);

    // Randomized traffic against the behavioural model.
    for (int n = 0; n < 300; n++) begin
      logic       en;
      logic [1:0] sel;
      for (int k = 0; k < 4; k++) model_codes[k] = 8'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      sel = 2'($urandom_range(0, 3));
      set_codes(model_codes[0], model_codes[1], model_codes[2], model_codes[3]);
      exp_q = en ? model_codes[sel] : 8'h00;
      step(en, sel);
      check_outputs($sformatf("rand%0d", n), exp_q, en);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
